disco_light_sequencer: RTL and testbench

- Parametrised successor of the single-floor LED rave engine. Drives NUM_FLOORS active-low LED floors of LED_WIDTH each from a shared beat prescaler.
- Four selectable patterns: counter, wave, bounce and blink. Patterns are selected via a valid/ready request handshake.
- Includes a panic blank, a debounced secret-combo override and per-floor MVB parity streaming.
- Sits between the party top level and the LED/shield pins.

---
 rtl/disco_pkg.sv | 37 +++
 rtl/disco_beat_prescaler.sv | 40 ++++
 rtl/disco_light_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_disco_light_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/disco_pkg.sv
// Shared definitions for the disco light sequencer.
// Holds the pattern mode encoding and a one-hot rotate helper that works
// on any floor width up to DISCO_MAX_W bits.
package disco_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WAVE   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // Widest floor the rotate helper supports.
    localparam int unsigned DISCO_MAX_W = 64;
    localparam int unsigned DISCO_IDX_W = $clog2(DISCO_MAX_W);

    // Rotate the low 'width' bits of val left by amt; bits at and above width stay 0.
    function automatic logic [DISCO_MAX_W-1:0] disco_rotl(
        input logic [DISCO_MAX_W-1:0] val,
        input int unsigned            width,
        input int unsigned            amt
    );
        logic [DISCO_MAX_W-1:0] res;
        logic [DISCO_IDX_W-1:0] src;
        logic [DISCO_IDX_W-1:0] dst;
        res = '0;
        for (int unsigned i = 0; i < DISCO_MAX_W; i++) begin
            if (i < width) begin
                src      = DISCO_IDX_W'(i);
                dst      = DISCO_IDX_W'((i + amt) % width);
                res[dst] = val[src];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/disco_beat_prescaler.sv
// Beat prescaler: divides clkDiscoMaster by TICK_DIV and produces a
// single-cycle internal tick while the count sits at TICK_DIV-1.
// Ports:
//   clkDiscoMaster - clock
//   partyReset     - synchronous active-high reset, count returns to 0
//   hold           - freezes the count and suppresses the tick
//   tick           - combinational, high in the last cycle of each beat
module disco_beat_prescaler #(
    parameter int unsigned TICK_DIV = 75000
) (
    input  logic clkDiscoMaster,
    input  logic partyReset,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !hold && (cnt_q == LastCnt);
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clkDiscoMaster) begin
        if (partyReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disco_light_sequencer.sv
// Disco light sequencer: drives NUM_FLOORS active-low LED floors from a
// shared beat prescaler with four patterns (count, wave, bounce, blink),
// a panic blank, a debounced secret-combo blink override and per-floor
// parity streaming.
// Ports:
//   clkDiscoMaster, partyReset       - clock, synchronous active-high reset
//   panicButton                      - level; blanks floors, freezes state
//   modeReq/modeReqValid/modeReqReady - pattern request handshake
//   secretSauceDials/Buttons         - secret combo inputs
//   danceFloor                       - active-low LEDs, floor k at [k*LED_WIDTH +: LED_WIDTH]
//   currentMode                      - pattern in effect
//   beatTick                         - one-cycle pulse per beat
//   secretActive                     - secret blink override in effect
//   mvbDiscoStrobe/mvbDiscoStream    - per-beat parity sample of each floor
module disco_light_sequencer
    import disco_pkg::*;
#(
    parameter int unsigned          LED_WIDTH   = 8,
    parameter int unsigned          NUM_FLOORS  = 2,
    parameter int unsigned          TICK_DIV    = 75000,
    parameter int unsigned          DIAL_WIDTH  = 12,
    parameter logic [DIAL_WIDTH-1:0] SECRET_CODE = 12'hACE,
    parameter int unsigned          SECRET_HOLD = 3
) (
    input  logic                            clkDiscoMaster,
    input  logic                            partyReset,
    input  logic                            panicButton,
    input  logic [1:0]                      modeReq,
    input  logic                            modeReqValid,
    output logic                            modeReqReady,
    input  logic [DIAL_WIDTH-1:0]           secretSauceDials,
    input  logic [1:0]                      secretSauceButtons,
    output logic [NUM_FLOORS*LED_WIDTH-1:0] danceFloor,
    output logic [1:0]                      currentMode,
    output logic                            beatTick,
    output logic                            secretActive,
    output logic                            mvbDiscoStrobe,
    output logic [NUM_FLOORS-1:0]           mvbDiscoStream
);

    localparam int unsigned FloorBits = NUM_FLOORS * LED_WIDTH;
    localparam int unsigned ComboW    = $clog2(SECRET_HOLD + 1);
    localparam logic [ComboW-1:0]    HoldVal = ComboW'(SECRET_HOLD);
    localparam logic [LED_WIDTH-1:0] TopPos  = LED_WIDTH'(LED_WIDTH - 1);

    logic tick;

    mode_e                 mode_q, mode_d;
    mode_e                 pend_mode_q, pend_mode_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  ready_q, ready_d;
    // Pattern state: count base, wave one-hot, bounce position or blink phase (bit 0).
    logic [LED_WIDTH-1:0]  pat_q, pat_d;
    logic                  dir_q, dir_d;  // bounce direction, 1 = moving down
    logic [ComboW-1:0]     combo_cnt_q, combo_cnt_d;
    logic                  secret_q, secret_d;
    logic                  sec_phase_q, sec_phase_d;
    logic [FloorBits-1:0]  disp_q, disp_d;  // active-high image last shown
    logic [FloorBits-1:0]  floor_q, floor_d;
    logic                  beat_q;
    logic [NUM_FLOORS-1:0] stream_q, stream_d;

    logic                  accept;
    logic                  apply;
    logic                  combo;
    logic [FloorBits-1:0]  pat_all;
    logic [NUM_FLOORS-1:0] parity;

    disco_beat_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clkDiscoMaster(clkDiscoMaster),
        .partyReset    (partyReset),
        .hold          (panicButton),
        .tick          (tick)
    );

    // Handshake, mode application and pattern state.
    always_comb begin
        accept       = modeReqValid && ready_q;
        // A request accepted in a tick cycle is not yet pending, so it waits a beat.
        apply        = tick && pend_valid_q;
        combo        = (secretSauceDials == SECRET_CODE) && (secretSauceButtons == 2'b11);

        mode_d       = mode_q;
        pend_mode_d  = pend_mode_q;
        pend_valid_d = pend_valid_q;
        ready_d      = ready_q;
        pat_d        = pat_q;
        dir_d        = dir_q;
        combo_cnt_d  = combo_cnt_q;
        secret_d     = secret_q;
        sec_phase_d  = sec_phase_q;

        if (accept) begin
            pend_mode_d  = mode_e'(modeReq);
            pend_valid_d = 1'b1;
            ready_d      = 1'b0;
        end

        if (apply) begin
            mode_d       = pend_mode_q;
            pend_valid_d = 1'b0;
            ready_d      = 1'b1;
            pat_d        = (pend_mode_q == MODE_WAVE) ? LED_WIDTH'(1) : '0;
            dir_d        = 1'b0;
        end else if (tick) begin
            unique case (mode_q)
                MODE_COUNT: pat_d = pat_q + 1'b1;
                MODE_WAVE:  pat_d = LED_WIDTH'(disco_rotl(DISCO_MAX_W'(pat_q), LED_WIDTH, 1));
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        pat_d = pat_q + 1'b1;
                        dir_d = (pat_d == TopPos);
                    end else begin
                        pat_d = pat_q - 1'b1;
                        dir_d = (pat_d != '0);
                    end
                end
                MODE_BLINK: pat_d = pat_q ^ LED_WIDTH'(1);
                default:    pat_d = pat_q;
            endcase
        end

        if (tick) begin
            if (!combo) begin
                combo_cnt_d = '0;
            end else if (combo_cnt_q != HoldVal) begin
                combo_cnt_d = combo_cnt_q + 1'b1;
            end
            secret_d    = (combo_cnt_d == HoldVal);
            // Override always opens on the all-on phase.
            sec_phase_d = secret_q ? !sec_phase_q : 1'b1;
        end
    end

    // Per-floor active-high pattern built from the next pattern state.
    for (genvar k = 0; k < NUM_FLOORS; k++) begin : g_floor
        localparam logic [LED_WIDTH-1:0] Offset = LED_WIDTH'(k);
        logic [LED_WIDTH-1:0] p;

        always_comb begin
            p = '0;
            unique case (mode_d)
                MODE_COUNT:  p = pat_d + Offset;
                MODE_WAVE:   p = LED_WIDTH'(disco_rotl(DISCO_MAX_W'(pat_d), LED_WIDTH, k));
                MODE_BOUNCE: p = LED_WIDTH'(1) << pat_d;
                MODE_BLINK:  p = {LED_WIDTH{pat_d[0]}};
                default:     p = '0;
            endcase
            if (secret_d) begin
                p = {LED_WIDTH{sec_phase_d}};
            end
        end

        assign pat_all[k*LED_WIDTH +: LED_WIDTH] = p;
        assign parity[k]                         = ^p;
    end

    // Display path: refresh on tick, blank under panic, restore on release.
    always_comb begin
        disp_d   = tick ? pat_all : disp_q;
        stream_d = tick ? parity : stream_q;
        floor_d  = panicButton ? '1 : ~disp_d;
    end

    always_ff @(posedge clkDiscoMaster) begin
        if (partyReset) begin
            mode_q       <= MODE_COUNT;
            pend_mode_q  <= MODE_COUNT;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            pat_q        <= '0;
            dir_q        <= 1'b0;
            combo_cnt_q  <= '0;
            secret_q     <= 1'b0;
            sec_phase_q  <= 1'b0;
            disp_q       <= '0;
            floor_q      <= '1;
            beat_q       <= 1'b0;
            stream_q     <= '0;
        end else begin
            mode_q       <= mode_d;
            pend_mode_q  <= pend_mode_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            pat_q        <= pat_d;
            dir_q        <= dir_d;
            combo_cnt_q  <= combo_cnt_d;
            secret_q     <= secret_d;
            sec_phase_q  <= sec_phase_d;
            disp_q       <= disp_d;
            floor_q      <= floor_d;
            beat_q       <= tick;
            stream_q     <= stream_d;
        end
    end

    assign modeReqReady   = ready_q;
    assign currentMode    = mode_q;
    assign beatTick       = beat_q;
    // The tick is already suppressed under panic, so the strobe shares the beat pulse.
    assign mvbDiscoStrobe = beat_q;
    assign secretActive   = secret_q;
    assign mvbDiscoStream = stream_q;
    assign danceFloor     = floor_q;

endmodule

// File: tb/tb_disco_light_sequencer.sv
module tb_disco_light_sequencer;

    logic        clk = 1'b0;
    logic        partyReset;
    logic        panicButton;
    logic [1:0]  modeReq;
    logic        modeReqValid;
    logic        modeReqReady;
    logic [11:0] dials;
    logic [1:0]  buttons;
    logic [15:0] danceFloor;
    logic [1:0]  currentMode;
    logic        beatTick;
    logic        secretActive;
    logic        strobe;
    logic [1:0]  stream;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] oh;
    int pos_seq [14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

    always #5 clk = ~clk;

    disco_light_sequencer #(
        .LED_WIDTH  (8),
        .NUM_FLOORS (2),
        .TICK_DIV   (4),
        .DIAL_WIDTH (12),
        .SECRET_CODE(12'hACE),
        .SECRET_HOLD(3)
    ) dut (
        .clkDiscoMaster    (clk),
        .partyReset        (partyReset),
        .panicButton       (panicButton),
        .modeReq           (modeReq),
        .modeReqValid      (modeReqValid),
        .modeReqReady      (modeReqReady),
        .secretSauceDials  (dials),
        .secretSauceButtons(buttons),
        .danceFloor        (danceFloor),
        .currentMode       (currentMode),
        .beatTick          (beatTick),
        .secretActive      (secretActive),
        .mvbDiscoStrobe    (strobe),
        .mvbDiscoStream    (stream)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_beat();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            step();
            seen = beatTick;
        end
        check("beat_timeout", 32'(seen), 32'd1);
    endtask

    task automatic request(input logic [1:0] m);
        modeReq      = m;
        modeReqValid = 1'b1;
        step();
        modeReqValid = 1'b0;
    endtask

    initial begin
        partyReset   = 1'b1;
        panicButton  = 1'b0;
        modeReq      = 2'd0;
        modeReqValid = 1'b0;
        dials        = 12'h000;
        buttons      = 2'b00;
        step();
        step();
        check("rst_floor", 32'(danceFloor), 32'hFFFF);
        check("rst_ready", 32'(modeReqReady), 32'd1);
        check("rst_mode", 32'(currentMode), 32'd0);
        check("rst_beat", 32'(beatTick), 32'd0);
        check("rst_secret", 32'(secretActive), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_stream", 32'(stream), 32'd0);
        partyReset = 1'b0;

        // First beat exactly four cycles after release.
        repeat (3) step();
        check("beat_early", 32'(beatTick), 32'd0);
        step();
        check("beat_first", 32'(beatTick), 32'd1);
        check("count_first", 32'(danceFloor), 32'hFDFE);
        check("count_stream", 32'(stream), 32'h3);
        check("count_strobe", 32'(strobe), 32'd1);

        // Bounce request; applied on next beat, then a full sweep.
        request(2'd2);
        check("bounce_ready_lo", 32'(modeReqReady), 32'd0);
        check("bounce_mode_old", 32'(currentMode), 32'd0);
        step();
        check("strobe_one_cycle", 32'(strobe), 32'd0);
        wait_beat();
        check("bounce_mode", 32'(currentMode), 32'd2);
        check("bounce_ready_hi", 32'(modeReqReady), 32'd1);
        check("bounce_init", 32'(danceFloor), 32'hFEFE);
        for (int i = 0; i < 14; i++) begin
            wait_beat();
            oh = 8'd1 << pos_seq[i];
            check("bounce_step", 32'(danceFloor), 32'({~oh, ~oh}));
        end

        // Wave, then panic mid-pattern.
        request(2'd1);
        wait_beat();
        check("wave_mode", 32'(currentMode), 32'd1);
        check("wave_init", 32'(danceFloor), 32'hFDFE);
        wait_beat();
        check("wave_1", 32'(danceFloor), 32'hFBFD);
        wait_beat();
        check("wave_2", 32'(danceFloor), 32'hF7FB);
        panicButton = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("panic_floor", 32'(danceFloor), 32'hFFFF);
            check("panic_strobe", 32'(strobe), 32'd0);
        end
        panicButton = 1'b0;
        step();
        check("panic_restore", 32'(danceFloor), 32'hF7FB);
        wait_beat();
        check("wave_resume", 32'(danceFloor), 32'hEFF7);

        // Count mode, then secret combo held for three beats.
        request(2'd0);
        wait_beat();
        check("count_init", 32'(danceFloor), 32'hFEFF);
        dials   = 12'hACE;
        buttons = 2'b11;
        wait_beat();
        check("combo_1", 32'(danceFloor), 32'hFDFE);
        check("combo_1_sec", 32'(secretActive), 32'd0);
        wait_beat();
        check("combo_2", 32'(danceFloor), 32'hFCFD);
        check("combo_2_sec", 32'(secretActive), 32'd0);
        wait_beat();
        check("secret_on", 32'(secretActive), 32'd1);
        check("secret_floor_on", 32'(danceFloor), 32'h0000);
        check("secret_stream", 32'(stream), 32'h0);
        wait_beat();
        check("secret_floor_off", 32'(danceFloor), 32'hFFFF);
        buttons = 2'b00;
        wait_beat();
        check("secret_off", 32'(secretActive), 32'd0);
        check("secret_release", 32'(danceFloor), 32'hF9FA);

        // Run the count up to the wrap point.
        repeat (249) wait_beat();
        check("count_fe", 32'(danceFloor), 32'h0001);
        wait_beat();
        check("count_ff", 32'(danceFloor), 32'hFF00);
        wait_beat();
        check("count_wrap", 32'(danceFloor), 32'hFEFF);
        check("wrap_stream", 32'(stream), 32'h2);
        check("wrap_strobe", 32'(strobe), 32'd1);
        step();
        check("wrap_strobe_lo", 32'(strobe), 32'd0);

        // Request in the internal tick cycle applies one beat later.
        step();
        step();
        request(2'd3);
        check("same_tick_beat", 32'(beatTick), 32'd1);
        check("same_tick_mode", 32'(currentMode), 32'd0);
        check("same_tick_ready", 32'(modeReqReady), 32'd0);
        check("same_tick_floor", 32'(danceFloor), 32'hFDFE);
        step();
        check("same_tick_ready2", 32'(modeReqReady), 32'd0);
        wait_beat();
        check("blink_mode", 32'(currentMode), 32'd3);
        check("blink_init", 32'(danceFloor), 32'hFFFF);
        wait_beat();
        check("blink_on", 32'(danceFloor), 32'h0000);
        wait_beat();
        check("blink_off", 32'(danceFloor), 32'hFFFF);

        // Reset abandons a pending request.
        request(2'd2);
        check("pend_ready", 32'(modeReqReady), 32'd0);
        partyReset = 1'b1;
        step();
        partyReset = 1'b0;
        check("rst2_ready", 32'(modeReqReady), 32'd1);
        check("rst2_mode", 32'(currentMode), 32'd0);
        check("rst2_floor", 32'(danceFloor), 32'hFFFF);
        repeat (3) step();
        check("rst2_beat_early", 32'(beatTick), 32'd0);
        step();
        check("rst2_beat", 32'(beatTick), 32'd1);
        check("rst2_mode_kept", 32'(currentMode), 32'd0);
        check("rst2_count", 32'(danceFloor), 32'hFDFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
